// File: rtl/router_pkg.sv
// Shared constants and types for the router output FIFO slice.
package router_pkg;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int PTR_W     = ADDR_W + 1;
    localparam int PKT_CNT_W = 7;

    // Header byte layout: [1:0] destination address, [7:2] payload length.
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    // One stored FIFO entry: header tag plus the raw byte.
    typedef struct packed {
        logic             hdr_flag;
        logic [WIDTH-1:0] data;
    } fifo_word_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for the router FIFO: synchronous write, asynchronous indexed read.
module router_fifo_mem
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH:0]    wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH:0]    rd_data
);

    fifo_word_t mem_q [DEPTH];

    // Capture the tagged word at the write pointer; contents are never cleared.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= fifo_word_t'(wr_data);
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router: pointers, flags, packet
// byte counter and the registered read port around a small storage array.
module router_fifo
    import router_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0]     data_out_q, data_out_d;

    logic       do_write;
    logic       do_read;
    logic       mem_wr_en;
    fifo_word_t wr_word;
    fifo_word_t rd_word;
    logic [WIDTH:0] rd_word_raw;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    assign do_write  = write_enb && !full && !soft_reset;
    assign do_read   = read_enb && !empty && !soft_reset;
    assign mem_wr_en = do_write && resetn;

    assign wr_word.hdr_flag = lfd_state;
    assign wr_word.data     = data_in;
    assign rd_word          = fifo_word_t'(rd_word_raw);

    router_fifo_mem u_mem (
        .clock   (clock),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (wr_word),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (rd_word_raw)
    );

    // Next-state: pointer advance, packet byte counting and read-port framing.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                data_out_d = rd_word.data;
                if (rd_word.hdr_flag) begin
                    pkt_cnt_d = PKT_CNT_W'(rd_word.data[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
                end
            end else if (pkt_cnt_q == '0) begin
                data_out_d = '0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
Per-destination output buffer of the 1x3 router; three instances sit directly downstream of the router register stage and capture its byte stream.
- Each stored word is tagged with a header flag so the read side can decode packet length and frame its output.
- The read port feeds a destination client.
- The FIFO's `full` feeds back to the register stage and FSM as `fifo_full`, through the synchronizer.

Parameters:
- WIDTH, 8, data byte width.
- DEPTH, 16, number of entries (power of two).
- ADDR_W, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock; upstream register stage updates on falling edge, giving half-cycle setup.
- resetn  input  1  synchronous, active-low reset.
- soft_reset  input  1  synchronous, active-high flush from the synchronizer's read timeout.
- write_enb  input  1  write request from the synchronizer.
- read_enb  input  1  read request from the destination client.
- lfd_state  input  1  high while the incoming byte is a packet header; stored as tag bit.
- data_in  input  WIDTH  byte from the register stage `dout`.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- data_out  output  WIDTH  registered read data.

Behaviour:
- Storage: DEPTH words of WIDTH+1 bits, laid out as {hdr_flag, byte}.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits; the extra MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and MSBs differ.
  - Both flags are combinational from the pointers.
- Write: on a rising edge with write_enb && !full, mem[wr_ptr] <= {lfd_state, data_in} and wr_ptr++. A write while full is dropped; the pointer does not move.
- Read: on a rising edge with read_enb && !empty, data_out <= mem[rd_ptr] byte and rd_ptr++. Latency is 1 cycle from the sampled read_enb to valid data_out. A read while empty is ignored.
- Packet counter pkt_cnt, 7 bits, tracks bytes remaining in the packet currently being read:
  - Read of a tagged word: pkt_cnt <= byte[7:2] + 1 (payload length plus parity byte).
  - Read of an untagged word with pkt_cnt != 0: pkt_cnt--.
  - Length field 0: pkt_cnt = 1, so only the parity byte follows.
- data_out idle rule: on a cycle with no read and pkt_cnt == 0, data_out <= 0. If the reader stalls mid-packet (pkt_cnt != 0), data_out holds.
- Simultaneous read and write:
  - Both succeed when 0 < occupancy < DEPTH; occupancy is unchanged and order is preserved.
  - When full, only the read succeeds.
  - When empty, only the write succeeds; no fall-through.
- Wrap-around: index bits wrap modulo DEPTH and the MSB toggles. No special casing is needed.
- resetn low: wr_ptr, rd_ptr, pkt_cnt and data_out are cleared to 0, giving full=0, empty=1. Memory contents are not reset.
- soft_reset high (resetn high): same clear as resetn in the same cycle. Any concurrent write or read that cycle is discarded. This applies mid-packet, dropping the remainder.
- Priority: resetn > soft_reset > read/write.
- Bytes stored verbatim; no parity checking here (done upstream).

Decomposition:
- Package router_pkg holds:
  - WIDTH, DEPTH.
  - Header field constants HDR_ADDR = [1:0], HDR_LEN = [7:2].
  - PKT_CNT_W = 7.
  - Typedef fifo_word_t for the {hdr_flag, byte} word.
- One sub-module is natural: router_fifo_mem, a simple dual-port array with a synchronous write and an indexed read. Pointers, flags and pkt_cnt stay in router_fifo.

Test Plan:
1. Reset: hold resetn=0 for 2 cycles, then release -> full=0, empty=1, data_out=8'h00; read_enb=1 while empty leaves data_out=0.
2. Single packet:
   - Stimulus: write header 8'h0D with lfd_state=1, then 8'h11, 8'h22, 8'h33 and parity 8'h0D; then hold read_enb=1.
   - data_out = 0D, 11, 22, 33, 0D on successive cycles, then 00; empty=1 after the 5th read.
3. Full boundary:
   - 16 writes 8'h00..8'h0F -> full=1 after the 16th edge.
   - A 17th write of 8'hFF is dropped.
   - One read returns 8'h00 and full drops.
   - Draining returns 01..0F with no FF.
4. Concurrent read and write at occupancy 8 for 10 cycles -> occupancy stays 8, empty=0, full=0, output order strictly FIFO.
5. Soft reset mid-packet:
   - Header 8'h14 (len 5), read header plus 2 bytes, then soft_reset=1 with write_enb=1 in the same cycle.
   - Next cycle: empty=1, data_out=0, pkt_cnt=0, and the written byte is absent.
6. Wrap-around and stall:
   - Stream 40 bytes while keeping occupancy ≤5 -> sequence intact across pointer wrap.
   - Deassert read_enb mid-packet for 3 cycles -> data_out holds its last byte and does not go to 0.
